dla_gb_port_arb: RTL and testbench
==================================

Name: dla_gb_port_arb

Overview:
- Shares the single global-buffer (GB) access port between two requesters: the SoC register-interface path (soc2gb) and the DMA loader (dma2gb).
- soc2gb has no backpressure. Its requests are therefore always accepted into a small queue.
- The DMA side uses a req/gnt handshake.
- The block drives the GB port with registered strobes and routes the 1-cycle-latency GB read data back to the requester that issued the read.

Parameters:
- SOC_Q_DEPTH, 2, depth of the soc request queue (≥1).
- MAX_DMA_RUN, 16, maximum consecutive DMA grants while dma_lock is held.
- GB_RD_LAT, 1, cycles from gb_ren to valid gb_rdata (fixed).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- soc_wen  in  1  soc write request
- soc_ren  in  1  soc read request
- soc_ab_sel  in  1  soc A/B bank select
- soc_addr  in  13  soc GB row address
- soc_ram_sel  in  16  soc RAM lane enables
- soc_wdata  in  256  soc write data
- soc_rdata  out  16x16  read data returned to soc
- soc_rvalid  out  1  soc read data valid, 1-cycle pulse
- soc_q_level  out  2  current soc queue occupancy
- dma_req  in  1  DMA access request
- dma_we  in  1  DMA access is a write (1) or read (0)
- dma_lock  in  1  DMA burst hold request
- dma_ab_sel  in  1  DMA bank select
- dma_addr  in  13  DMA row address
- dma_ram_sel  in  16  DMA RAM lane enables
- dma_wdata  in  256  DMA write data
- dma_gnt  out  1  DMA request accepted this cycle (combinational)
- dma_rdata  out  16x16  read data returned to DMA
- dma_rvalid  out  1  DMA read data valid
- gb_ab_sel  out  1  GB bank select
- gb_addr  out  13  GB address
- gb_ram_sel  out  16  GB lane enables
- gb_wdata  out  256  GB write data
- gb_wen  out  1  GB write strobe
- gb_ren  out  1  GB read strobe
- gb_rdata  in  16x16  GB read data

Behaviour:
- Reset: every output register clears to 0 (gb_*, soc_rdata, soc_rvalid, dma_rdata, dma_rvalid). Queue empties, run counter goes to 0, in-flight read tags clear. Reset asserted mid-read discards that read; no rvalid is produced for it.
- soc request: a cycle with soc_wen|soc_ren. If both are set, it is a write and the read is ignored. The soc request is always accepted.
  - If the queue is empty and soc wins arbitration this cycle, it bypasses the queue.
  - Otherwise it is pushed to the queue tail.
- Arbitration, evaluated each cycle. Soc candidate = queue head if the queue is non-empty, else the incoming request.
  - Queue full → soc wins.
  - Else dma_req & dma_lock & run_cnt < MAX_DMA_RUN → DMA wins.
  - Else soc candidate present → soc wins.
  - Else dma_req → DMA wins.
- dma_gnt = 1 exactly in cycles where DMA wins. The DMA holds its request fields stable until gnt.
- run_cnt:
  - Increments on each locked DMA grant.
  - Clears when dma_lock = 0, or on any soc grant.
  - Saturates at MAX_DMA_RUN. The lock is broken, soc is served, and the count restarts.
- Full-queue handling: a push and a pop in the same cycle are legal. Because a full queue forces a pop, the queue never overflows.
- Issue: the winner's fields are registered onto gb_* on the next edge. gb_wen/gb_ren are 1-cycle pulses. When the port is idle, gb_wen = gb_ren = 0 and the address/data fields hold their last values.
- Read latency: a bypass soc read presented in cycle t gives gb_ren at t+1, gb_rdata at t+2, and soc_rdata/soc_rvalid registered at t+3. This matches the existing soc2gb rvalid timing. Queued requests add one cycle per queue wait.
- Read return: a 1-bit owner tag is pipelined alongside gb_ren for GB_RD_LAT+1 stages. At the capture stage, only the owner's rdata register loads and only the owner's rvalid pulses. The other requester's rdata holds its value.
- Ordering: soc requests complete in issue order. Writes are fire-and-forget; there is no write ack.

Decomposition:
- Package PKG_dla_gb_arb:
  - typedef gb_req_t {ab_sel, addr[12:0], ram_sel[15:0], wdata[255:0], wen, ren}
  - enum owner_e {OWN_SOC, OWN_DMA}
  - constants GB_ADDR_W = 13, GB_LANES = 16
- One sub-module: dla_gb_req_fifo.
  - Parameterised by depth, stores gb_req_t.
  - Provides push/pop/level/full/empty.
  - Supports simultaneous push+pop when full.

Test Plan:
- Idle soc read, addr 0x0123, ram_sel 0x0003, no DMA → gb_ren at t+1 with gb_addr 0x0123; soc_rvalid at t+3 with soc_rdata = gb_rdata of t+2; dma_rvalid stays 0.
- soc write in the same cycle as an unlocked dma_req → soc issues first; dma_gnt=0 that cycle, then dma_gnt=1 the next cycle; gb_wen pulses on two consecutive cycles.
- DMA holds dma_lock+dma_req for 20 cycles while soc writes on cycles 3 and 4 → the first queued soc write waits, the queue reaches full, and soc is forced when the queue is full or run_cnt=16; soc_q_level never exceeds 2; all soc writes reach gb_* in order.
- Interleaved reads soc@0x0010, dma@0x0020, soc@0x0030 → rvalids arrive on the correct owner in order; the non-owner's rdata register is unchanged.
- soc_wen and soc_ren both high → only gb_wen pulses; no soc_rvalid.
- rst pulsed one cycle after gb_ren for a DMA read → all outputs are 0 after reset; no dma_rvalid follows; queue level is 0.

Source files
------------

// File: rtl/dla_gb_port_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : PKG_dla_gb_arb
// Brief   : Shared types and constants for the GB port arbiter slice.
// Revision: 1.0 - initial release
// ============================================================================
package PKG_dla_gb_arb;

  localparam int GB_ADDR_W = 13;
  localparam int GB_LANES  = 16;
  localparam int GB_LANE_W = 16;
  localparam int GB_DATA_W = GB_LANES * GB_LANE_W;

  // One GB port access as it travels from requester to the port registers
  typedef struct packed {
    logic                 ab_sel;
    logic [GB_ADDR_W-1:0] addr;
    logic [GB_LANES-1:0]  ram_sel;
    logic [GB_DATA_W-1:0] wdata;
    logic                 wen;
    logic                 ren;
  } gb_req_t;

  // Which requester a read in flight belongs to
  typedef enum logic {
    OWN_SOC = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/dla_gb_req_fifo.sv
`default_nettype none
// ============================================================================
// Module  : dla_gb_req_fifo
// Brief   : Small circular queue of gb_req_t entries. A pop frees the head
//           slot in the same cycle, so push+pop while full is accepted.
// Revision: 1.0 - initial release
// ============================================================================
module dla_gb_req_fifo
  import PKG_dla_gb_arb::*;
#(
  parameter int DEPTH = 2,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  gb_req_t          push_data,
  input  logic             pop,
  output gb_req_t          head,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  gb_req_t          mem_q [DEPTH];
  gb_req_t          mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pointer/occupancy update; a push into a full queue only lands if the head leaves
  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    do_push  = push && ((cnt_q != LVL_FULL) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + LVL_W'(1);
      2'b01:   cnt_d = cnt_q - LVL_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Queue state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = cnt_q;
  assign full  = (cnt_q == LVL_FULL);
  assign empty = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/dla_gb_port_arb.sv
`default_nettype none
// ============================================================================
// Module  : dla_gb_port_arb
// Brief   : Arbitrates the single GB port between the soc2gb path (no
//           backpressure, queued) and the DMA loader (req/gnt, optional
//           lock for bursts). Read data is steered back by an owner tag.
// Revision: 1.0 - initial release
// ============================================================================
module dla_gb_port_arb
  import PKG_dla_gb_arb::*;
#(
  parameter int SOC_Q_DEPTH = 2,
  parameter int MAX_DMA_RUN = 16,
  parameter int GB_RD_LAT   = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 soc_wen,
  input  logic                                 soc_ren,
  input  logic                                 soc_ab_sel,
  input  logic [GB_ADDR_W-1:0]                 soc_addr,
  input  logic [GB_LANES-1:0]                  soc_ram_sel,
  input  logic [GB_DATA_W-1:0]                 soc_wdata,
  output logic [GB_LANES-1:0][GB_LANE_W-1:0]   soc_rdata,
  output logic                                 soc_rvalid,
  output logic [1:0]                           soc_q_level,
  input  logic                                 dma_req,
  input  logic                                 dma_we,
  input  logic                                 dma_lock,
  input  logic                                 dma_ab_sel,
  input  logic [GB_ADDR_W-1:0]                 dma_addr,
  input  logic [GB_LANES-1:0]                  dma_ram_sel,
  input  logic [GB_DATA_W-1:0]                 dma_wdata,
  output logic                                 dma_gnt,
  output logic [GB_LANES-1:0][GB_LANE_W-1:0]   dma_rdata,
  output logic                                 dma_rvalid,
  output logic                                 gb_ab_sel,
  output logic [GB_ADDR_W-1:0]                 gb_addr,
  output logic [GB_LANES-1:0]                  gb_ram_sel,
  output logic [GB_DATA_W-1:0]                 gb_wdata,
  output logic                                 gb_wen,
  output logic                                 gb_ren,
  input  logic [GB_LANES-1:0][GB_LANE_W-1:0]   gb_rdata
);

  localparam int               RUN_W   = $clog2(MAX_DMA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DMA_RUN);

  gb_req_t    soc_in, dma_in, q_head, soc_cand;
  gb_req_t    gb_req_q, gb_req_d;
  logic       soc_vld, cand_vld;
  logic       q_full, q_empty, q_push, q_pop;
  logic       soc_win, dma_win;
  logic [1:0] q_level;

  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [GB_RD_LAT:0] rd_vld_q, rd_vld_d;
  owner_e             rd_own_q [GB_RD_LAT+1];
  owner_e             rd_own_d [GB_RD_LAT+1];

  logic [GB_LANES-1:0][GB_LANE_W-1:0] soc_rdata_q, soc_rdata_d;
  logic [GB_LANES-1:0][GB_LANE_W-1:0] dma_rdata_q, dma_rdata_d;
  logic                               soc_rvalid_q, soc_rvalid_d;
  logic                               dma_rvalid_q, dma_rvalid_d;

  // Normalise both requesters into gb_req_t; a soc write+read collapses to a write
  always_comb begin
    soc_vld        = soc_wen | soc_ren;
    soc_in.ab_sel  = soc_ab_sel;
    soc_in.addr    = soc_addr;
    soc_in.ram_sel = soc_ram_sel;
    soc_in.wdata   = soc_wdata;
    soc_in.wen     = soc_wen;
    soc_in.ren     = soc_ren & ~soc_wen;
    dma_in.ab_sel  = dma_ab_sel;
    dma_in.addr    = dma_addr;
    dma_in.ram_sel = dma_ram_sel;
    dma_in.wdata   = dma_wdata;
    dma_in.wen     = dma_we;
    dma_in.ren     = ~dma_we;
  end

  // Priority: full queue, then an unexpired DMA lock, then soc, then plain DMA
  always_comb begin
    soc_cand = q_empty ? soc_in : q_head;
    cand_vld = ~q_empty | soc_vld;
    dma_win  = ~q_full & dma_req &
               ((dma_lock & (run_cnt_q < RUN_MAX)) | ~cand_vld);
    soc_win  = ~dma_win & cand_vld;
    q_pop    = soc_win & ~q_empty;
    // Bypass only when nothing is waiting ahead and soc owns the port now
    q_push   = soc_vld & ~(q_empty & soc_win);
  end

  dla_gb_req_fifo #(
    .DEPTH (SOC_Q_DEPTH),
    .LVL_W (2)
  ) u_soc_q (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (soc_in),
    .pop       (q_pop),
    .head      (q_head),
    .level     (q_level),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Next-state for port issue, lock run counter, owner tag pipe and return data
  always_comb begin
    gb_req_d     = gb_req_q;
    gb_req_d.wen = 1'b0;
    gb_req_d.ren = 1'b0;
    if (soc_win) begin
      gb_req_d = soc_cand;
    end else if (dma_win) begin
      gb_req_d = dma_in;
    end

    run_cnt_d = run_cnt_q;
    if (soc_win || !dma_lock) begin
      run_cnt_d = '0;
    end else if (dma_win && (run_cnt_q < RUN_MAX)) begin
      run_cnt_d = run_cnt_q + RUN_W'(1);
    end

    rd_vld_d[0] = gb_req_d.ren;
    rd_own_d[0] = dma_win ? OWN_DMA : OWN_SOC;
    for (int i = 1; i <= GB_RD_LAT; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
      rd_own_d[i] = rd_own_q[i-1];
    end

    soc_rdata_d  = soc_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    soc_rvalid_d = 1'b0;
    dma_rvalid_d = 1'b0;
    if (rd_vld_q[GB_RD_LAT]) begin
      if (rd_own_q[GB_RD_LAT] == OWN_SOC) begin
        soc_rdata_d  = gb_rdata;
        soc_rvalid_d = 1'b1;
      end else begin
        dma_rdata_d  = gb_rdata;
        dma_rvalid_d = 1'b1;
      end
    end
  end

  // Arbiter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gb_req_q     <= '0;
      run_cnt_q    <= '0;
      rd_vld_q     <= '0;
      for (int i = 0; i <= GB_RD_LAT; i++) rd_own_q[i] <= OWN_SOC;
      soc_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      soc_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      gb_req_q     <= gb_req_d;
      run_cnt_q    <= run_cnt_d;
      rd_vld_q     <= rd_vld_d;
      rd_own_q     <= rd_own_d;
      soc_rdata_q  <= soc_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      soc_rvalid_q <= soc_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  assign dma_gnt     = dma_win;
  assign soc_q_level = q_level;
  assign gb_ab_sel   = gb_req_q.ab_sel;
  assign gb_addr     = gb_req_q.addr;
  assign gb_ram_sel  = gb_req_q.ram_sel;
  assign gb_wdata    = gb_req_q.wdata;
  assign gb_wen      = gb_req_q.wen;
  assign gb_ren      = gb_req_q.ren;
  assign soc_rdata   = soc_rdata_q;
  assign soc_rvalid  = soc_rvalid_q;
  assign dma_rdata   = dma_rdata_q;
  assign dma_rvalid  = dma_rvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_dla_gb_port_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_dla_gb_port_arb
// Brief   : Self-checking bench for dla_gb_port_arb: directed scenarios plus
//           randomized traffic compared against a queue-based reference.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dla_gb_port_arb;
  import PKG_dla_gb_arb::*;

  localparam int DEPTH  = 2;
  localparam int MAXRUN = 16;
  localparam int LAT    = 1;
  localparam int W_NONE = 0;
  localparam int W_SOC  = 1;
  localparam int W_DMA  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic soc_wen, soc_ren, soc_ab_sel;
  logic [12:0] soc_addr;
  logic [15:0] soc_ram_sel;
  logic [255:0] soc_wdata;
  logic [15:0][15:0] soc_rdata, dma_rdata, gb_rdata;
  logic soc_rvalid, dma_rvalid;
  logic [1:0] soc_q_level;
  logic dma_req, dma_we, dma_lock, dma_ab_sel, dma_gnt;
  logic [12:0] dma_addr;
  logic [15:0] dma_ram_sel;
  logic [255:0] dma_wdata;
  logic gb_ab_sel, gb_wen, gb_ren;
  logic [12:0] gb_addr;
  logic [15:0] gb_ram_sel;
  logic [255:0] gb_wdata;

  dla_gb_port_arb #(.SOC_Q_DEPTH(DEPTH), .MAX_DMA_RUN(MAXRUN), .GB_RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .soc_wen(soc_wen), .soc_ren(soc_ren), .soc_ab_sel(soc_ab_sel), .soc_addr(soc_addr),
    .soc_ram_sel(soc_ram_sel), .soc_wdata(soc_wdata), .soc_rdata(soc_rdata),
    .soc_rvalid(soc_rvalid), .soc_q_level(soc_q_level),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_ab_sel(dma_ab_sel),
    .dma_addr(dma_addr), .dma_ram_sel(dma_ram_sel), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .gb_ab_sel(gb_ab_sel), .gb_addr(gb_addr), .gb_ram_sel(gb_ram_sel), .gb_wdata(gb_wdata),
    .gb_wen(gb_wen), .gb_ren(gb_ren), .gb_rdata(gb_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  typedef struct {
    int     cyc;
    owner_e own;
  } pend_t;

  gb_req_t      mq[$];          // soc requests waiting, in order
  pend_t        pq[$];          // reads in flight, by capture cycle
  int           run;            // consecutive locked DMA grants
  int           cyc;
  gb_req_t      exp_gb;
  logic [255:0] exp_soc_rd, exp_dma_rd;
  logic         exp_soc_rv, exp_dma_rv;

  // stimulus state
  logic    s_wen, s_ren;
  gb_req_t sstim;
  bit      dpend;
  gb_req_t dreq;
  logic    dlock;

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic gb_req_t rand_req();
    gb_req_t r;
    r.ab_sel  = 1'($urandom);
    r.addr    = 13'($urandom);
    r.ram_sel = 16'($urandom);
    r.wdata   = rand256();
    r.wen     = 1'b0;
    r.ren     = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    pq.delete();
    run        = 0;
    exp_gb     = '0;
    exp_soc_rd = '0;
    exp_dma_rd = '0;
    exp_soc_rv = 1'b0;
    exp_dma_rv = 1'b0;
    dpend      = 1'b0;
  endtask

  task automatic check_outputs();
    chk("gb_wen", gb_wen, exp_gb.wen);
    chk("gb_ren", gb_ren, exp_gb.ren);
    chk("gb_ab_sel", gb_ab_sel, exp_gb.ab_sel);
    chk("gb_addr", gb_addr, exp_gb.addr);
    chk("gb_ram_sel", gb_ram_sel, exp_gb.ram_sel);
    chk("gb_wdata", gb_wdata, exp_gb.wdata);
    chk("soc_rvalid", soc_rvalid, exp_soc_rv);
    chk("soc_rdata", soc_rdata, exp_soc_rd);
    chk("dma_rvalid", dma_rvalid, exp_dma_rv);
    chk("dma_rdata", dma_rdata, exp_dma_rd);
    chk("soc_q_level", soc_q_level, 256'(mq.size()));
  endtask

  // One clock of traffic: check registered outputs, apply stimulus, advance model
  task automatic step();
    gb_req_t      sreq, cand;
    logic [255:0] cur_rd;
    int           win, qs;
    logic         sv;
    pend_t        p;
    @(negedge clk);
    check_outputs();
    soc_wen     = s_wen;       soc_ren     = s_ren;
    soc_ab_sel  = sstim.ab_sel; soc_addr   = sstim.addr;
    soc_ram_sel = sstim.ram_sel; soc_wdata = sstim.wdata;
    dma_req     = dpend;       dma_we      = dreq.wen;
    dma_lock    = dlock;       dma_ab_sel  = dreq.ab_sel;
    dma_addr    = dreq.addr;   dma_ram_sel = dreq.ram_sel;
    dma_wdata   = dreq.wdata;
    cur_rd      = rand256();
    gb_rdata    = cur_rd;
    #1;
    sv       = s_wen | s_ren;
    sreq     = sstim;
    sreq.wen = s_wen;
    sreq.ren = s_ren & ~s_wen;
    qs       = mq.size();
    cand     = (qs > 0) ? mq[0] : sreq;
    if (qs == DEPTH)                        win = W_SOC;
    else if (dpend && dlock && run < MAXRUN) win = W_DMA;
    else if (qs > 0 || sv)                  win = W_SOC;
    else if (dpend)                         win = W_DMA;
    else                                    win = W_NONE;
    chk("dma_gnt", dma_gnt, 256'(win == W_DMA));
    // read return captured at the end of this cycle
    exp_soc_rv = 1'b0;
    exp_dma_rv = 1'b0;
    if (pq.size() > 0 && pq[0].cyc == cyc) begin
      p = pq.pop_front();
      if (p.own == OWN_SOC) begin exp_soc_rd = cur_rd; exp_soc_rv = 1'b1; end
      else                  begin exp_dma_rd = cur_rd; exp_dma_rv = 1'b1; end
    end
    // port issue
    if (win == W_SOC) begin
      exp_gb = cand;
      if (cand.ren) pq.push_back('{cyc + 1 + LAT, OWN_SOC});
    end else if (win == W_DMA) begin
      exp_gb = dreq;
      if (dreq.ren) pq.push_back('{cyc + 1 + LAT, OWN_DMA});
      dpend = 1'b0;
    end else begin
      exp_gb.wen = 1'b0;
      exp_gb.ren = 1'b0;
    end
    // soc queue
    if (win == W_SOC && qs > 0) void'(mq.pop_front());
    if (sv && !(win == W_SOC && qs == 0)) mq.push_back(sreq);
    // lock run length
    if (win == W_SOC || !dlock) run = 0;
    else if (win == W_DMA && run < MAXRUN) run++;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    rst     = 1'b1;
    soc_wen = 1'b0;
    soc_ren = 1'b0;
    dma_req = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
  endtask

  task automatic soc_idle();
    s_wen = 1'b0;
    s_ren = 1'b0;
    sstim = rand_req();
  endtask

  task automatic soc_op(input logic w, input logic r, input logic [12:0] a, input logic [15:0] rs);
    sstim         = rand_req();
    sstim.addr    = a;
    sstim.ram_sel = rs;
    s_wen         = w;
    s_ren         = r;
  endtask

  task automatic dma_op(input logic we, input logic [12:0] a);
    dreq      = rand_req();
    dreq.addr = a;
    dreq.wen  = we;
    dreq.ren  = ~we;
    dpend     = 1'b1;
  endtask

  task automatic gen_random(input int p_soc, input int p_dma, input int p_flip);
    int op;
    if ($urandom_range(0, 99) < p_soc) begin
      op = $urandom_range(1, 3);
      soc_op(op[0], op[1], 13'($urandom), 16'($urandom));
    end else begin
      soc_idle();
    end
    if (!dpend && $urandom_range(0, 99) < p_dma) dma_op(1'($urandom), 13'($urandom));
    if ($urandom_range(0, 99) < p_flip) dlock = ~dlock;
  endtask

  initial begin
    soc_wen = 0; soc_ren = 0; soc_ab_sel = 0; soc_addr = '0; soc_ram_sel = '0; soc_wdata = '0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_ab_sel = 0; dma_addr = '0; dma_ram_sel = '0;
    dma_wdata = '0; gb_rdata = '0;
    cyc   = 0;
    dlock = 1'b0;
    dreq  = '0;
    model_reset();
    soc_idle();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // idle soc read with bypass latency
    soc_op(1'b0, 1'b1, 13'h0123, 16'h0003);
    step();
    soc_idle();
    repeat (4) step();

    // soc write collides with an unlocked DMA write: soc first, DMA next cycle
    soc_op(1'b1, 1'b0, 13'h0040, 16'hffff);
    dma_op(1'b1, 13'h0041);
    step();
    soc_idle();
    repeat (3) step();

    // write+read together is a write only
    soc_op(1'b1, 1'b1, 13'h0055, 16'h00f0);
    step();
    soc_idle();
    repeat (4) step();

    // interleaved reads soc / dma / soc
    soc_op(1'b0, 1'b1, 13'h0010, 16'h0001);
    step();
    soc_idle();
    dma_op(1'b0, 13'h0020);
    step();
    soc_op(1'b0, 1'b1, 13'h0030, 16'h0002);
    step();
    soc_idle();
    repeat (5) step();

    // locked DMA burst with soc writes arriving mid-burst
    dlock = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (!dpend) dma_op(1'b1, 13'(16'h0100 + i));
      if (i == 3 || i == 4) soc_op(1'b1, 1'b0, 13'(16'h0200 + i), 16'h00ff);
      else soc_idle();
      step();
    end
    dlock = 1'b0;
    dpend = 1'b0;
    soc_idle();
    repeat (3) step();

    // DMA read, then reset while that read is in flight
    dma_op(1'b0, 13'h0777);
    for (int i = 0; i < 8 && dpend; i++) step();
    if (dpend) chk("dma_gnt_timeout", 256'(1), 256'(0));
    do_reset();
    soc_idle();
    repeat (4) step();

    // randomized phases: balanced, lock-heavy, busy with resets, saturated lock
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 400; i++) begin
        case (ph)
          0: gen_random(30, 50, 5);
          1: gen_random(15, 90, 2);
          2: gen_random(60, 60, 10);
          default: begin dlock = 1'b1; gen_random(5, 100, 0); end
        endcase
        if (ph == 2 && $urandom_range(0, 149) == 0) begin
          do_reset();
          soc_idle();
        end
        step();
      end
    end
    dlock = 1'b0;
    soc_idle();
    dpend = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
